// File: rtl/wisc_pkg.sv
// -----------------------------------------------------------------------------
// wisc_pkg
// Shared definitions for the WISC core: opcode encodings, branch condition
// codes, flag-register bit positions, the PC-stage state type and the
// branch-offset helper.
// -----------------------------------------------------------------------------
package wisc_pkg;

    // Opcodes (instr[15:12]) that the PC stage cares about
    localparam logic [3:0] OP_B   = 4'b1100;
    localparam logic [3:0] OP_BR  = 4'b1101;
    localparam logic [3:0] OP_HLT = 4'b1111;

    // Branch condition codes (instr[11:9])
    localparam logic [2:0] COND_NEQ    = 3'b000;
    localparam logic [2:0] COND_EQ     = 3'b001;
    localparam logic [2:0] COND_GT     = 3'b010;
    localparam logic [2:0] COND_LT     = 3'b011;
    localparam logic [2:0] COND_GTE    = 3'b100;
    localparam logic [2:0] COND_LTE    = 3'b101;
    localparam logic [2:0] COND_OVFL   = 3'b110;
    localparam logic [2:0] COND_UNCOND = 3'b111;

    // Bit positions inside the {Z, V, N} flag vector
    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_N = 0;

    // PC-stage state: HALTED is sticky until reset
    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } pc_state_e;

    // Sign-extend a 9-bit word offset and convert it to a byte offset
    function automatic logic [15:0] b_offset(input logic [8:0] imm);
        return {{6{imm[8]}}, imm, 1'b0};
    endfunction

endpackage : wisc_pkg

// File: rtl/branch_control.sv
// -----------------------------------------------------------------------------
// branch_control
// Evaluates a 3-bit branch condition against the {Z, V, N} flags.
// Ports:
//   br_condition  in  3 : condition code from instr[11:9]
//   flags_out     in  3 : {Z, V, N} from the flag register
//   br_true       out 1 : condition holds
// -----------------------------------------------------------------------------
module branch_control
    import wisc_pkg::*;
(
    input  logic [2:0] br_condition,
    input  logic [2:0] flags_out,
    output logic       br_true
);

    logic z_s;
    logic v_s;
    logic n_s;

    assign z_s = flags_out[FLAG_Z];
    assign v_s = flags_out[FLAG_V];
    assign n_s = flags_out[FLAG_N];

    // Condition decode
    always_comb begin
        br_true = 1'b0;
        case (br_condition)
            COND_NEQ:    br_true = ~z_s;
            COND_EQ:     br_true = z_s;
            COND_GT:     br_true = ~z_s & ~n_s;
            COND_LT:     br_true = n_s;
            COND_GTE:    br_true = z_s | ~n_s;
            COND_LTE:    br_true = z_s | n_s;
            COND_OVFL:   br_true = v_s;
            COND_UNCOND: br_true = 1'b1;
            default:     br_true = 1'b0;
        endcase
    end

endmodule : branch_control

// File: rtl/pc_control.sv
// -----------------------------------------------------------------------------
// pc_control
// Program-counter stage of the single-cycle WISC core. Holds the PC, picks
// the next PC (sequential, B, BR or HLT), tracks the RUN/HALTED state and
// keeps saturating branch statistics.
// Parameters:
//   RESET_PC              : PC loaded on reset
// Ports:
//   clk            in  1  : core clock, rising edge
//   rst            in  1  : asynchronous active-high reset
//   instr          in  16 : fetched instruction at pc
//   flags          in  3  : {Z, V, N}
//   rs_data        in  16 : register read data, BR target
//   stall          in  1  : hold PC and all state this cycle
//   pc             out 16 : current PC
//   pc_plus2       out 16 : pc + 2 (wraps)
//   br_taken       out 1  : current B/BR is taken (combinational)
//   halted         out 1  : HLT has been executed
//   br_count       out 16 : committed B/BR, saturating
//   br_taken_count out 16 : committed taken B/BR, saturating
// -----------------------------------------------------------------------------
module pc_control
    import wisc_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] instr,
    input  logic [2:0]  flags,
    input  logic [15:0] rs_data,
    input  logic        stall,
    output logic [15:0] pc,
    output logic [15:0] pc_plus2,
    output logic        br_taken,
    output logic        halted,
    output logic [15:0] br_count,
    output logic [15:0] br_taken_count
);

    pc_state_e   state_q;
    pc_state_e   state_d;
    logic [15:0] pc_q;
    logic [15:0] pc_d;
    logic [15:0] br_count_q;
    logic [15:0] br_count_d;
    logic [15:0] br_taken_count_q;
    logic [15:0] br_taken_count_d;

    logic [3:0]  opcode_s;
    logic        is_b_s;
    logic        is_br_s;
    logic        is_hlt_s;
    logic        br_true_s;
    logic        commit_s;
    logic [15:0] pc_plus2_s;
    logic [15:0] b_target_s;

    assign opcode_s   = instr[15:12];
    assign is_b_s     = (opcode_s == OP_B);
    assign is_br_s    = (opcode_s == OP_BR);
    assign is_hlt_s   = (opcode_s == OP_HLT);
    assign pc_plus2_s = pc_q + 16'd2;
    assign b_target_s = pc_plus2_s + b_offset(instr[8:0]);
    // Nothing retires while stalled or once halted
    assign commit_s   = (state_q == ST_RUN) && !stall;

    branch_control u_branch_control (
        .br_condition (instr[11:9]),
        .flags_out    (flags),
        .br_true      (br_true_s)
    );

    // Next-PC, next-state and counter update selection
    always_comb begin
        state_d          = state_q;
        pc_d             = pc_q;
        br_count_d       = br_count_q;
        br_taken_count_d = br_taken_count_q;
        br_taken         = (is_b_s || is_br_s) && br_true_s && (state_q == ST_RUN);

        if (commit_s) begin
            if (is_hlt_s) begin
                state_d = ST_HALTED;
                pc_d    = pc_q;
            end else if (br_taken && is_b_s) begin
                pc_d = b_target_s;
            end else if (br_taken && is_br_s) begin
                pc_d = rs_data;
            end else begin
                pc_d = pc_plus2_s;
            end

            if (is_b_s || is_br_s) begin
                // Counters stick at all-ones instead of wrapping
                if (br_count_q != 16'hFFFF) begin
                    br_count_d = br_count_q + 16'd1;
                end else begin
                    br_count_d = br_count_q;
                end
                if (br_taken && (br_taken_count_q != 16'hFFFF)) begin
                    br_taken_count_d = br_taken_count_q + 16'd1;
                end else begin
                    br_taken_count_d = br_taken_count_q;
                end
            end else begin
                br_count_d       = br_count_q;
                br_taken_count_d = br_taken_count_q;
            end
        end else begin
            state_d = state_q;
        end
    end

    // PC, state and statistics registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= ST_RUN;
            pc_q             <= RESET_PC;
            br_count_q       <= 16'h0000;
            br_taken_count_q <= 16'h0000;
        end else begin
            state_q          <= state_d;
            pc_q             <= pc_d;
            br_count_q       <= br_count_d;
            br_taken_count_q <= br_taken_count_d;
        end
    end

    assign pc             = pc_q;
    assign pc_plus2       = pc_plus2_s;
    assign halted         = (state_q == ST_HALTED);
    assign br_count       = br_count_q;
    assign br_taken_count = br_taken_count_q;

endmodule : pc_control

// File: tb/tb_pc_control.sv
// -----------------------------------------------------------------------------
// tb_pc_control
// Table-driven bench for pc_control with a queue of expected post-edge state.
// -----------------------------------------------------------------------------
module tb_pc_control;

    typedef struct {
        logic [15:0] instr;
        logic [2:0]  flags;
        logic [15:0] rs_data;
        logic        stall;
        logic        exp_taken;
        logic [15:0] exp_pc;
        logic [15:0] exp_brc;
        logic [15:0] exp_btc;
        logic        exp_halted;
    } vec_t;

    typedef struct {
        logic [15:0] pc;
        logic [15:0] brc;
        logic [15:0] btc;
        logic        halted;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [15:0] instr;
    logic [2:0]  flags;
    logic [15:0] rs_data;
    logic        stall;
    logic [15:0] pc;
    logic [15:0] pc_plus2;
    logic        br_taken;
    logic        halted;
    logic [15:0] br_count;
    logic [15:0] br_taken_count;

    int n_checks = 0;
    int n_fail   = 0;
    exp_t sb_q[$];
    vec_t vecs[25];

    pc_control #(.RESET_PC(16'h0000)) dut (
        .clk            (clk),
        .rst            (rst),
        .instr          (instr),
        .flags          (flags),
        .rs_data        (rs_data),
        .stall          (stall),
        .pc             (pc),
        .pc_plus2       (pc_plus2),
        .br_taken       (br_taken),
        .halted         (halted),
        .br_count       (br_count),
        .br_taken_count (br_taken_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", name, act, exp, $time);
        end
    endtask

    // Check the whole visible state against one expected record
    task automatic chk_state(input string name, input exp_t e);
        chk({name, ".pc"}, pc, e.pc);
        chk({name, ".pc_plus2"}, pc_plus2, e.pc + 16'd2);
        chk({name, ".br_count"}, br_count, e.brc);
        chk({name, ".br_taken_count"}, br_taken_count, e.btc);
        chk({name, ".halted"}, {15'd0, halted}, {15'd0, e.halted});
    endtask

    // Drive one vector, check br_taken, then check the post-edge state
    task automatic apply_vec(input vec_t v, input string name);
        exp_t e;
        exp_t got;
        instr   = v.instr;
        flags   = v.flags;
        rs_data = v.rs_data;
        stall   = v.stall;
        #1;
        chk({name, ".br_taken"}, {15'd0, br_taken}, {15'd0, v.exp_taken});
        e.pc     = v.exp_pc;
        e.brc    = v.exp_brc;
        e.btc    = v.exp_btc;
        e.halted = v.exp_halted;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            got = sb_q.pop_front();
            chk_state(name, got);
        end
    endtask

    function automatic vec_t mk(input logic [15:0] i, input logic [2:0] f,
                                input logic [15:0] r, input logic s, input logic t,
                                input logic [15:0] p, input logic [15:0] bc,
                                input logic [15:0] tc, input logic h);
        vec_t v;
        v.instr = i; v.flags = f; v.rs_data = r; v.stall = s;
        v.exp_taken = t; v.exp_pc = p; v.exp_brc = bc; v.exp_btc = tc; v.exp_halted = h;
        return v;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        exp_t e0;
        vec_t v;

        //               instr     flags   rs_data   st    tk    pc        brc     btc     h
        vecs[0]  = mk(16'h0000, 3'b000, 16'h0000, 1'b0, 1'b0, 16'h0002, 16'd0,  16'd0,  1'b0);
        vecs[1]  = mk(16'h0000, 3'b000, 16'h0000, 1'b0, 1'b0, 16'h0004, 16'd0,  16'd0,  1'b0);
        vecs[2]  = mk(16'h0000, 3'b000, 16'h0000, 1'b0, 1'b0, 16'h0006, 16'd0,  16'd0,  1'b0);
        vecs[3]  = mk(16'hDE10, 3'b000, 16'h0010, 1'b0, 1'b1, 16'h0010, 16'd1,  16'd1,  1'b0);
        vecs[4]  = mk(16'hCE05, 3'b000, 16'h0000, 1'b0, 1'b1, 16'h001C, 16'd2,  16'd2,  1'b0);
        vecs[5]  = mk(16'hDE10, 3'b000, 16'h0010, 1'b0, 1'b1, 16'h0010, 16'd3,  16'd3,  1'b0);
        vecs[6]  = mk(16'hCFFF, 3'b000, 16'h0000, 1'b0, 1'b1, 16'h0010, 16'd4,  16'd4,  1'b0);
        vecs[7]  = mk(16'hC005, 3'b100, 16'h0000, 1'b0, 1'b0, 16'h0012, 16'd5,  16'd4,  1'b0);
        vecs[8]  = mk(16'hC005, 3'b000, 16'h0000, 1'b0, 1'b1, 16'h001E, 16'd6,  16'd5,  1'b0);
        vecs[9]  = mk(16'hDE10, 3'b000, 16'h1234, 1'b1, 1'b1, 16'h001E, 16'd6,  16'd5,  1'b0);
        vecs[10] = mk(16'hDE10, 3'b000, 16'h1234, 1'b0, 1'b1, 16'h1234, 16'd7,  16'd6,  1'b0);
        vecs[11] = mk(16'h2345, 3'b111, 16'hFFFF, 1'b0, 1'b0, 16'h1236, 16'd7,  16'd6,  1'b0);
        vecs[12] = mk(16'hC405, 3'b000, 16'h0000, 1'b0, 1'b1, 16'h1242, 16'd8,  16'd7,  1'b0);
        vecs[13] = mk(16'hC602, 3'b000, 16'h0000, 1'b0, 1'b0, 16'h1244, 16'd9,  16'd7,  1'b0);
        vecs[14] = mk(16'hCC02, 3'b010, 16'h0000, 1'b0, 1'b1, 16'h124A, 16'd10, 16'd8,  1'b0);
        vecs[15] = mk(16'hCA01, 3'b001, 16'h0000, 1'b0, 1'b1, 16'h124E, 16'd11, 16'd9,  1'b0);
        vecs[16] = mk(16'hC801, 3'b001, 16'h0000, 1'b0, 1'b0, 16'h1250, 16'd12, 16'd9,  1'b0);
        vecs[17] = mk(16'hC201, 3'b100, 16'h0000, 1'b0, 1'b1, 16'h1254, 16'd13, 16'd10, 1'b0);
        vecs[18] = mk(16'hDE10, 3'b000, 16'hFFFE, 1'b0, 1'b1, 16'hFFFE, 16'd14, 16'd11, 1'b0);
        vecs[19] = mk(16'h0000, 3'b000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'd14, 16'd11, 1'b0);
        vecs[20] = mk(16'hCFFE, 3'b000, 16'h0000, 1'b0, 1'b1, 16'hFFFE, 16'd15, 16'd12, 1'b0);
        vecs[21] = mk(16'h0000, 3'b000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'd15, 16'd12, 1'b0);
        vecs[22] = mk(16'hF000, 3'b000, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'd15, 16'd12, 1'b0);
        vecs[23] = mk(16'hDE10, 3'b000, 16'h0040, 1'b0, 1'b1, 16'h0040, 16'd16, 16'd13, 1'b0);
        vecs[24] = mk(16'hF000, 3'b000, 16'h0000, 1'b0, 1'b0, 16'h0040, 16'd16, 16'd13, 1'b1);

        instr = 16'h0000; flags = 3'b000; rs_data = 16'h0000; stall = 1'b0;
        do_reset();

        // Reset state
        e0.pc = 16'h0000; e0.brc = 16'd0; e0.btc = 16'd0; e0.halted = 1'b0;
        chk_state("reset", e0);

        foreach (vecs[i]) begin
            apply_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Halted: a taken B must not move the PC or the counters
        for (int k = 0; k < 10; k++) begin
            apply_vec(mk(16'hCE05, 3'b000, 16'h0000, 1'b0, 1'b0, 16'h0040,
                         16'd16, 16'd13, 1'b1), $sformatf("halted%0d", k));
        end

        // Asynchronous reset mid-cycle clears everything without an edge
        #3;
        rst = 1'b1;
        #1;
        chk_state("async_rst", e0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk_state("after_rst", e0);

        // Saturation: one not-taken branch then taken branches in place
        apply_vec(mk(16'hC005, 3'b100, 16'h0000, 1'b0, 1'b0, 16'h0002,
                     16'd1, 16'd0, 1'b0), "sat_nt");
        instr = 16'hCFFF; flags = 3'b000; stall = 1'b0;
        repeat (16'hFFFD) @(posedge clk);
        #1;
        e0.pc = 16'h0002; e0.brc = 16'hFFFE; e0.btc = 16'hFFFD; e0.halted = 1'b0;
        chk_state("sat_preload", e0);
        apply_vec(mk(16'hCFFF, 3'b000, 16'h0000, 1'b0, 1'b1, 16'h0002,
                     16'hFFFF, 16'hFFFE, 1'b0), "sat_1");
        apply_vec(mk(16'hCFFF, 3'b000, 16'h0000, 1'b0, 1'b1, 16'h0002,
                     16'hFFFF, 16'hFFFF, 1'b0), "sat_2");
        apply_vec(mk(16'hCFFF, 3'b000, 16'h0000, 1'b0, 1'b1, 16'h0002,
                     16'hFFFF, 16'hFFFF, 1'b0), "sat_3");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_pc_control
